// File: rtl/pt_check.sv
// Scans a length-prefixed plaintext buffer and reports whether every message byte is printable.
// Latency: 2+2L edges on pass, 2+2k on first bad byte k; en is accepted only while rdy=1.
module pt_check #(
  parameter logic [7:0] LO_CHAR = 8'h20,
  parameter logic [7:0] HI_CHAR = 8'h7E
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic       pass,
  output logic [7:0] err_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_LEN,
    S_GET_LEN,
    S_ISSUE,
    S_CHECK
  } state_t;

  state_t     r_state, w_nxt_state;
  logic [7:0] r_addr, w_nxt_addr;
  logic [7:0] r_idx, w_nxt_idx;
  logic [7:0] r_len, w_nxt_len;
  logic [7:0] r_err, w_nxt_err;
  logic       r_pass, w_nxt_pass;
  logic       w_printable;

  assign w_printable = (pt_rddata >= LO_CHAR) && (pt_rddata <= HI_CHAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= 8'd0;
      r_idx   <= 8'd0;
      r_len   <= 8'd0;
      r_err   <= 8'd0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_addr  <= w_nxt_addr;
      r_idx   <= w_nxt_idx;
      r_len   <= w_nxt_len;
      r_err   <= w_nxt_err;
      r_pass  <= w_nxt_pass;
    end
  end

  // pt_addr is registered one state early so the memory sees it during ISSUE/ISSUE_LEN.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_addr  = r_addr;
    w_nxt_idx   = r_idx;
    w_nxt_len   = r_len;
    w_nxt_err   = r_err;
    w_nxt_pass  = r_pass;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_nxt_state = S_ISSUE_LEN;
          w_nxt_addr  = 8'd0;
          w_nxt_pass  = 1'b0;
          w_nxt_err   = 8'd0;
        end
      end
      S_ISSUE_LEN: w_nxt_state = S_GET_LEN;
      S_GET_LEN: begin
        w_nxt_len = pt_rddata;
        if (pt_rddata == 8'd0) begin
          w_nxt_state = S_IDLE;
          w_nxt_pass  = 1'b1;
        end else begin
          w_nxt_idx   = 8'd1;
          w_nxt_addr  = 8'd1;
          w_nxt_state = S_ISSUE;
        end
      end
      S_ISSUE: w_nxt_state = S_CHECK;
      S_CHECK: begin
        if (!w_printable) begin
          w_nxt_state = S_IDLE;
          w_nxt_pass  = 1'b0;
          w_nxt_err   = r_idx;
        end else if (r_idx == r_len) begin
          // Terminating on equality keeps index 255 from ever wrapping.
          w_nxt_state = S_IDLE;
          w_nxt_pass  = 1'b1;
          w_nxt_err   = 8'd0;
        end else begin
          w_nxt_idx   = r_idx + 8'd1;
          w_nxt_addr  = r_idx + 8'd1;
          w_nxt_state = S_ISSUE;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  assign rdy      = (r_state == S_IDLE);
  assign pt_addr  = r_addr;
  assign pass     = r_pass;
  assign err_addr = r_err;

endmodule

// File: tb/tb_pt_check.sv
// Directed bench for pt_check: table of length/fill/bad-byte vectors plus reset and back-to-back sequences.
module tb_pt_check;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic [7:0] pt_addr;
  logic [7:0] pt_rddata;
  logic       pass;
  logic [7:0] err_addr;

  logic [7:0] mem [256];
  int total = 0;
  int bad   = 0;

  pt_check dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .rdy      (rdy),
    .pt_addr  (pt_addr),
    .pt_rddata(pt_rddata),
    .pass     (pass),
    .err_addr (err_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) pt_rddata <= mem[pt_addr];

  typedef struct {
    logic [7:0] len;
    logic [7:0] fill;
    logic [7:0] bad_idx;
    logic [7:0] bad_val;
    logic       exp_pass;
    logic [7:0] exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
  endtask

  task automatic start_run(input string name);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_accept_rdy"}, rdy, 0);
    check({name, "_clear_pass"}, pass, 0);
    en = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat, input logic exp_pass,
                           input logic [7:0] exp_err, input logic [7:0] exp_max);
    int n;
    logic [7:0] mx;
    n  = 0;
    mx = pt_addr;
    while (n < 600) begin
      @(posedge clk);
      n++;
      #1;
      if (pt_addr > mx) mx = pt_addr;
      if (rdy) break;
    end
    check({name, "_lat"}, n, exp_lat);
    check({name, "_pass"}, pass, exp_pass);
    check({name, "_err"}, err_addr, exp_err);
    check({name, "_maxaddr"}, mx, exp_max);
  endtask

  initial begin
    en    = 1'b0;
    rst_n = 1'b0;
    clear_mem();

    //            len    fill   bidx   bval   pass  err    lat
    vecs[0]  = '{8'd0,   8'h41, 8'd0,  8'h41, 1'b1, 8'd0,   2};
    vecs[1]  = '{8'd5,   8'h78, 8'd0,  8'h78, 1'b1, 8'd0,  12};
    vecs[2]  = '{8'd5,   8'h20, 8'd0,  8'h20, 1'b1, 8'd0,  12};
    vecs[3]  = '{8'd5,   8'h7E, 8'd0,  8'h7E, 1'b1, 8'd0,  12};
    vecs[4]  = '{8'd5,   8'h6D, 8'd1,  8'h7F, 1'b0, 8'd1,   4};
    vecs[5]  = '{8'd5,   8'h6D, 8'd5,  8'h1F, 1'b0, 8'd5,  12};
    vecs[6]  = '{8'd1,   8'h00, 8'd0,  8'h00, 1'b0, 8'd1,   4};
    vecs[7]  = '{8'd8,   8'h71, 8'd3,  8'h80, 1'b0, 8'd3,   8};
    vecs[8]  = '{8'd8,   8'h71, 8'd8,  8'hFF, 1'b0, 8'd8,  18};
    vecs[9]  = '{8'd255, 8'h7E, 8'd255, 8'h7F, 1'b0, 8'd255, 512};
    vecs[10] = '{8'd255, 8'h7E, 8'd255, 8'h20, 1'b1, 8'd0, 512};
    vecs[11] = '{8'd2,   8'h21, 8'd2,  8'h7D, 1'b1, 8'd0,   6};

    #1;
    check("reset_rdy", rdy, 1);
    check("reset_pass", pass, 0);
    check("reset_err", err_addr, 0);
    check("reset_addr", pt_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    clear_mem();
    mem[0] = 8'd3; mem[1] = "A"; mem[2] = "b"; mem[3] = "~";
    start_run("ex_Ab");
    wait_done("ex_Ab", 8, 1'b1, 8'd0, 8'd3);

    clear_mem();
    mem[0] = 8'd4; mem[1] = "a"; mem[2] = 8'h1F; mem[3] = "c"; mem[4] = "d";
    start_run("ex_ctrl");
    wait_done("ex_ctrl", 6, 1'b0, 8'd2, 8'd2);

    clear_mem();
    start_run("ex_empty");
    wait_done("ex_empty", 2, 1'b1, 8'd0, 8'd0);

    for (int i = 0; i < 12; i++) begin
      clear_mem();
      mem[0] = vecs[i].len;
      for (int a = 1; a <= int'(vecs[i].len); a++) mem[a] = vecs[i].fill;
      if (vecs[i].bad_idx != 8'd0) mem[vecs[i].bad_idx] = vecs[i].bad_val;
      start_run($sformatf("vec%0d", i));
      wait_done($sformatf("vec%0d", i), vecs[i].exp_lat, vecs[i].exp_pass, vecs[i].exp_err,
                vecs[i].exp_pass ? vecs[i].len : vecs[i].exp_err);
    end

    // Reset in the middle of an L=10 run, with en held high through reset.
    clear_mem();
    mem[0] = 8'd10;
    for (int a = 1; a <= 10; a++) mem[a] = "k";
    start_run("midrst");
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    en    = 1'b1;
    #1;
    check("midrst_rdy", rdy, 1);
    check("midrst_pass", pass, 0);
    check("midrst_err", err_addr, 0);
    check("midrst_addr", pt_addr, 0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst_hold_rdy%0d", k), rdy, 1);
      check($sformatf("rst_hold_addr%0d", k), pt_addr, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_accept", rdy, 0);
    en = 1'b0;
    wait_done("restart", 22, 1'b1, 8'd0, 8'd10);

    // en held high across two back-to-back runs.
    clear_mem();
    mem[0] = 8'd1; mem[1] = "Z";
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_accept1", rdy, 0);
    wait_done("b2b_run1", 4, 1'b1, 8'd0, 8'd1);
    @(posedge clk);
    #1;
    check("b2b_one_cycle_rdy", rdy, 0);
    check("b2b_clear_pass", pass, 0);
    en = 1'b0;
    wait_done("b2b_run2", 4, 1'b1, 8'd0, 8'd1);
    @(posedge clk);
    #1;
    check("b2b_stay_idle", rdy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
